// File: rtl/run_detector_if.sv
// Bus bundle for run_detector: sample controls, channel data and detection outputs.
// The sticky signals exist only when RUN_DETECTOR_STICKY_EN is defined.
interface run_detector_if #(
  parameter int CH    = 4,
  parameter int EVT_W = 8
);
  logic             en;
  logic             mode;
  logic [CH-1:0]    X;
  logic [CH-1:0]    Z;
  logic [EVT_W-1:0] evt_cnt;
`ifdef RUN_DETECTOR_STICKY_EN
  logic [CH-1:0]    sticky;
  logic [CH-1:0]    sticky_clr;
`endif

  modport master (
    output en,
    output mode,
    output X,
`ifdef RUN_DETECTOR_STICKY_EN
    output sticky_clr,
    input  sticky,
`endif
    input  Z,
    input  evt_cnt
  );

  modport slave (
    input  en,
    input  mode,
    input  X,
`ifdef RUN_DETECTOR_STICKY_EN
    input  sticky_clr,
    output sticky,
`endif
    output Z,
    output evt_cnt
  );
endinterface

// File: rtl/run_detector.sv
// Per-channel run-length detector with level/pulse outputs and a saturating event counter.
// Optional per-channel sticky flags are built when RUN_DETECTOR_STICKY_EN is defined.
module run_detector #(
  parameter int CH      = 4,
  parameter int RUN_LEN = 3,
  parameter int EVT_W   = 8
) (
  input logic           clk,
  input logic           reset,
  run_detector_if.slave bus
);
  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] DETECT = 2'd2;

  logic [CNT_W-1:0] cnt     [CH];
  logic [CNT_W-1:0] cnt_nxt [CH];
  logic [1:0]       st      [CH];
  logic [1:0]       st_nxt  [CH];
  logic [CH-1:0]    hit;
  logic [CH-1:0]    z_q;
  logic [CH-1:0]    z_nxt;
  logic [EVT_W-1:0] evt_q;
  logic [EVT_W-1:0] evt_nxt;
  logic [EVT_W:0]   pop;
  logic [EVT_W:0]   sum;

  // State follows the counter; a hit is the single edge that enters DETECT.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (bus.en) begin
        if (!bus.X[i])
          cnt_nxt[i] = '0;
        else if (cnt[i] != RUN_MAX)
          cnt_nxt[i] = cnt[i] + CNT_ONE;
      end
      if (cnt_nxt[i] == '0)
        st_nxt[i] = IDLE;
      else if (cnt_nxt[i] == RUN_MAX)
        st_nxt[i] = DETECT;
      else
        st_nxt[i] = COUNT;
      hit[i]   = (st[i] != DETECT) && (st_nxt[i] == DETECT);
      z_nxt[i] = bus.mode ? hit[i] : (st_nxt[i] == DETECT);
    end
  end

  // One spare bit in the sum absorbs up to 16 simultaneous hits before saturating.
  always_comb begin
    pop = '0;
    for (int i = 0; i < CH; i++)
      pop = pop + (EVT_W + 1)'(hit[i]);
    sum     = {1'b0, evt_q} + pop;
    evt_nxt = sum[EVT_W] ? {EVT_W{1'b1}} : sum[EVT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
        st[i]  <= IDLE;
      end
      z_q   <= '0;
      evt_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= cnt_nxt[i];
        st[i]  <= st_nxt[i];
      end
      z_q   <= z_nxt;
      evt_q <= evt_nxt;
    end
  end

  assign bus.Z       = z_q;
  assign bus.evt_cnt = evt_q;

`ifdef RUN_DETECTOR_STICKY_EN
  logic [CH-1:0] sticky_q;

  // Set has priority over a same-edge clear so no event is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sticky_q <= '0;
    else
      sticky_q <= (sticky_q & ~bus.sticky_clr) | hit;
  end

  assign bus.sticky = sticky_q;
`endif
endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, range 1..16.
REQ-002 Parameter RUN_LEN, default 3: consecutive high samples needed for detection, range 1..255.
REQ-003 Parameter EVT_W, default 8: width of the detection event counter, range 4..32.
REQ-004 Derived constant CNT_W = clog2(RUN_LEN+1): per-channel run counter width, not overridable.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  sample enable; inputs are sampled only when en=1.
REQ-008 mode  input  1  0 = level output, 1 = pulse output.
REQ-009 X  input  CH  per-channel data inputs.
REQ-010 Z  output  CH  per-channel registered detection outputs.
REQ-011 evt_cnt  output  EVT_W  saturating count of detection events, summed over all channels.
REQ-012 sticky  output  CH  per-channel sticky detect flags; present only with RUN_DETECTOR_STICKY_EN.
REQ-013 sticky_clr  input  CH  per-channel sticky clear strobes; present only with RUN_DETECTOR_STICKY_EN.

Function
REQ-014 Each channel SHALL run its own FSM: IDLE (cnt=0), COUNT (0<cnt<RUN_LEN) and DETECT (cnt=RUN_LEN).
REQ-015 On an edge with en=1 and X[i]=1, cnt[i] SHALL increment, saturating at RUN_LEN.
REQ-016 On an edge with en=1 and X[i]=0, cnt[i] SHALL clear to 0 from any state.
REQ-017 On an edge with en=0, cnt[i] and the state SHALL hold.
REQ-018 A detection event on channel i SHALL be the edge on which the state enters DETECT from IDLE or COUNT.
REQ-019 With RUN_LEN=1, the FSM SHALL go directly IDLE->DETECT and COUNT SHALL be unreachable.
REQ-020 Level mode: Z[i] SHALL equal 1 exactly while channel i is in DETECT, updated on the same edge as the state.
REQ-021 Pulse mode: Z[i] SHALL be 1 for exactly one cycle following each detection event, and 0 otherwise.
REQ-022 Pulse mode with held X=1: no further pulse SHALL occur until X[i] has been sampled 0 and a new full run completes.
REQ-023 Latency: Z[i] SHALL rise in the cycle after the RUN_LEN-th consecutive enabled edge that samples X[i]=1.
REQ-024 Level mode: Z[i] SHALL fall in the cycle after the first enabled edge that samples X[i]=0.
REQ-025 en=0: Z SHALL hold in level mode and be forced 0 in pulse mode.
REQ-026 A mode change SHALL take effect on the next edge and SHALL NOT alter cnt or state.
REQ-027 evt_cnt SHALL add, on each edge, the number of channels with a detection event on that edge (popcount).
REQ-028 evt_cnt SHALL saturate at 2^EVT_W-1 and never wrap.
REQ-029 A detection event SHALL be counted in evt_cnt on the same edge on which Z rises.

Reset
REQ-030 While reset=0: all cnt=0, all FSMs in IDLE, Z=0, evt_cnt=0 and sticky=0, asynchronously.
REQ-031 A reset asserted mid-run SHALL discard partial runs; after release, a full RUN_LEN run is required for detection.
REQ-032 The first sampling edge SHALL be the first rising clk edge after reset deasserts.

Configuration
REQ-033 With RUN_DETECTOR_STICKY_EN defined: sticky[i] SHALL set on each detection event on channel i and clear on an edge with sticky_clr[i]=1.
REQ-034 Under RUN_DETECTOR_STICKY_EN, a detection event and sticky_clr[i] on the same edge SHALL leave sticky[i]=1 (set wins).
REQ-035 Without RUN_DETECTOR_STICKY_EN, the sticky and sticky_clr ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-036 Level mode, CH=4, RUN_LEN=3: X[0]=1 for 5 enabled edges, then 0 -> Z[0] high from the cycle after edge 3 through edge 5, low after edge 6; evt_cnt=1.
REQ-037 Pulse mode: X[1]=1 for 6 edges -> Z[1] high exactly one cycle after edge 3; evt_cnt=1; after X[1]=0 for one edge and 3 more high edges, a second pulse occurs and evt_cnt=2.
REQ-038 Pattern 1,1,0,1,1,1 on X[2] -> no detection after edges 1-2; Z[2] rises only after edge 6.
REQ-039 en=0 for 2 cycles in mid-run (cnt=2), then en=1 with X=1 -> detection on the first enabled edge, with no reset of the count.
REQ-040 All 4 channels detect on the same edge with EVT_W=4 and evt_cnt=13 -> evt_cnt=15 (saturated), not 1.
REQ-041 reset=0 asserted while cnt=2 -> Z=0 and evt_cnt=0 immediately; after release, 3 more high edges are needed; with RUN_DETECTOR_STICKY_EN, simultaneous detect and clear leaves sticky=1.
